// File: rtl/array_ram.sv
// array_ram: single-port synchronous word memory behind a valid/ready
// request handshake. After reset the whole array is zeroed one word per
// cycle (CLEAR). Then each accepted request returns the word's previous
// contents and, for a write, stores the new data (read-first).
// The response data port is named dout because "do" is a reserved word.
module array_ram #(
  parameter int N = 8,
  parameter int A = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [A-1:0] addr,
  input  logic         we,
  input  logic [N-1:0] di,
  input  logic         valid,
  output logic [N-1:0] dout,
  output logic         ready
);

  localparam int DEPTH = 2 ** A;
  localparam logic [A-1:0] PTR_LAST = {A{1'b1}};
  localparam logic [A-1:0] PTR_ONE  = A'(1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [A-1:0] ptr;
  logic [A-1:0] ptr_next;

  logic [N-1:0] mem [0:DEPTH-1];

  logic         accept;
  logic         mem_we;
  logic [A-1:0] mem_waddr;
  logic [N-1:0] mem_wdata;

  // A request is taken only in IDLE, and never while the previous response
  // is still being presented, so a held valid yields one op per two cycles.
  assign accept = (state == IDLE) && valid && !ready;

  // Next-state logic: CLEAR walks ptr across every word, then IDLE forever.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      CLEAR: begin
        ptr_next = ptr + PTR_ONE;
        if (ptr == PTR_LAST) begin
          state_next = IDLE;
        end else begin
          state_next = CLEAR;
        end
      end
      IDLE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = CLEAR;
        ptr_next   = {A{1'b0}};
      end
    endcase
  end

  // State and clear-pointer registers; reset restarts CLEAR from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= {A{1'b0}};
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Select the single memory write port: clearing, or an accepted write.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ptr;
    mem_wdata = {N{1'b0}};
    if (rst) begin
      mem_we = 1'b0;
    end else if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = ptr;
      mem_wdata = {N{1'b0}};
    end else if (accept && we) begin
      mem_we    = 1'b1;
      mem_waddr = addr;
      mem_wdata = di;
    end else begin
      mem_we = 1'b0;
    end
  end

  // Memory array write; no reset here, CLEAR zeroes the contents instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered response: old word at addr and a one-cycle ready pulse.
  // dout keeps its value until the next accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready <= 1'b0;
      dout  <= {N{1'b0}};
    end else if (accept) begin
      ready <= 1'b1;
      dout  <= mem[addr];
    end else begin
      ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_array_ram.sv
// tb_array_ram: directed scoreboard bench for array_ram. Stimulus tasks push
// the expected response data into a queue; a monitor on the falling edge pops
// and compares whenever ready is high.
module tb_array_ram;

  logic       clk;
  logic       rst;
  logic [7:0] addr;
  logic       we;
  logic [7:0] di;
  logic       valid;
  logic [7:0] dout;
  logic       ready;

  logic [7:0] exp_q [$];
  int         chk_cnt;
  int         pass_cnt;
  logic       prev_ready;

  array_ram #(.N(8), .A(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .we    (we),
    .di    (di),
    .valid (valid),
    .dout  (dout),
    .ready (ready)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    chk_cnt++;
    if (act === want) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: every ready pulse consumes one expected response.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      check("no_back_to_back_ready", {31'd0, prev_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        check("resp_data", {24'd0, dout}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_ready = (ready === 1'b1);
  end

  // Reset is sampled at the rising edge between two falling edges.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Single request issued at a falling edge while idle; expects ready after one edge.
  task automatic req(input logic [7:0] a, input logic w, input logic [7:0] d, input logic [7:0] exp);
    int n;
    exp_q.push_back(exp);
    addr  = a;
    we    = w;
    di    = d;
    valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready !== 1'b1 && n < 50);
    valid = 1'b0;
    check("req_latency", n, 32'd1);
    if (ready !== 1'b1 && exp_q.size() > 0) begin
      void'(exp_q.pop_back());
    end
    @(negedge clk);
  endtask

  // Request held from a given cycle after reset; checks which cycle first shows ready.
  task automatic held_req(input logic [7:0] a, input int delay, input logic [7:0] exp, input int want_idx);
    int idx;
    bit seen;
    idx  = 0;
    seen = 1'b0;
    if (delay == 0) begin
      exp_q.push_back(exp);
      addr = a; we = 1'b0; di = 8'h00; valid = 1'b1;
    end
    while (!seen && idx < 400) begin
      @(negedge clk);
      idx++;
      if (ready === 1'b1) begin
        seen = 1'b1;
      end else if (idx == delay) begin
        exp_q.push_back(exp);
        addr = a; we = 1'b0; di = 8'h00; valid = 1'b1;
      end
    end
    valid = 1'b0;
    check("first_ready_cycle", seen ? idx : -1, want_idx);
    if (!seen && exp_q.size() > 0) begin
      void'(exp_q.pop_back());
    end
    @(negedge clk);
  endtask

  initial begin
    int pulses;
    int rdy_seen;
    chk_cnt    = 0;
    pass_cnt   = 0;
    prev_ready = 1'b0;
    rst   = 1'b1;
    addr  = 8'h00;
    we    = 1'b0;
    di    = 8'h00;
    valid = 1'b0;

    // 1: reset, full CLEAR, then reads of zeroed words
    do_reset();
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_dout", {24'd0, dout}, 32'd0);
    rdy_seen = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (ready === 1'b1) rdy_seen++;
    end
    check("ready_in_clear", rdy_seen, 32'd0);
    req(8'h00, 1'b0, 8'h00, 8'h00);
    req(8'h7F, 1'b0, 8'h00, 8'h00);
    req(8'hFF, 1'b0, 8'h00, 8'h00);

    // 2: write returns old value, read returns new value
    req(8'h10, 1'b1, 8'h5A, 8'h00);
    req(8'h10, 1'b0, 8'h00, 8'h5A);

    // 3: back-to-back writes to one word
    req(8'h20, 1'b1, 8'h11, 8'h00);
    req(8'h20, 1'b1, 8'h22, 8'h11);
    req(8'h20, 1'b0, 8'h00, 8'h22);

    // 4: held read of addr 3 for 6 cycles -> 3 pulses
    req(8'h03, 1'b1, 8'hC3, 8'h00);
    for (int i = 0; i < 3; i++) exp_q.push_back(8'hC3);
    addr = 8'h03; we = 1'b0; di = 8'h00; valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
    end
    valid = 1'b0;
    check("held_valid_pulses", pulses, 32'd3);
    @(negedge clk);

    // 5: request raised 5 cycles into CLEAR waits for the first IDLE edge
    do_reset();
    held_req(8'h40, 5, 8'h00, 257);

    // 6: reset in the middle of CLEAR restarts it from word 0
    req(8'hF0, 1'b1, 8'hAB, 8'h00);
    req(8'h10, 1'b1, 8'h77, 8'h00);
    do_reset();
    rdy_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready === 1'b1) rdy_seen++;
    end
    do_reset();
    check("ready_in_cut_clear", rdy_seen, 32'd0);
    check("rereset_dout", {24'd0, dout}, 32'd0);
    held_req(8'h10, 0, 8'h00, 257);
    req(8'hF0, 1'b0, 8'h00, 8'h00);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
